// File: rtl/router_pkt_tx_pkg.sv
// rtl/router_pkt_tx_pkg.sv - shared router packet field widths, constants and FSM state type
package router_pkt_tx_pkg;

    localparam int LEN_W  = 6;
    localparam int ADDR_W = 2;

    localparam logic [ADDR_W-1:0] ADDR_INVALID    = 2'b11;
    localparam logic [7:0]        PARITY_ERR_MASK = 8'h01;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HEADER,
        ST_PAYLOAD,
        ST_PARITY
    } tx_state_t;

endpackage

// File: rtl/router_pkt_tx.sv
// rtl/router_pkt_tx.sv - packet transmitter: header, payload and parity bytes toward the router
module router_pkt_tx
    import router_pkt_tx_pkg::*;
(
    input  logic              clock,
    input  logic              resetn,
    input  logic              start,
    input  logic [ADDR_W-1:0] dest_addr,
    input  logic [LEN_W-1:0]  payload_len,
    input  logic              err_inj,
    input  logic [7:0]        pl_data,
    input  logic              busy,
    output logic              pl_rd,
    output logic [7:0]        data_out,
    output logic              pkt_valid,
    output logic              ready,
    output logic              done,
    output logic              addr_err
);

    tx_state_t         state_q, state_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  rem_q, rem_d;
    logic              err_q, err_d;
    logic [7:0]        parity_q, parity_d;
    logic [7:0]        data_q, data_d;
    logic              valid_q, valid_d;
    logic              done_q, done_d;
    logic              addr_err_q, addr_err_d;
    logic              xfer;
    logic [7:0]        parity_byte;

    assign xfer        = !busy;
    assign parity_byte = parity_q ^ (err_q ? PARITY_ERR_MASK : 8'h00);

    assign pl_rd     = xfer && (((state_q == ST_HEADER)  && (len_q != '0)) ||
                                ((state_q == ST_PAYLOAD) && (rem_q != '0)));
    assign ready     = (state_q == ST_IDLE);
    assign data_out  = data_q;
    assign pkt_valid = valid_q;
    assign done      = done_q;
    assign addr_err  = addr_err_q;

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        rem_d      = rem_q;
        err_d      = err_q;
        parity_d   = parity_q;
        data_d     = data_q;
        valid_d    = valid_q;
        done_d     = 1'b0;
        addr_err_d = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (dest_addr == ADDR_INVALID) begin
                        addr_err_d = 1'b1;
                    end else begin
                        len_d    = payload_len;
                        err_d    = err_inj;
                        data_d   = {payload_len, dest_addr};
                        parity_d = {payload_len, dest_addr};
                        valid_d  = 1'b1;
                        state_d  = ST_HEADER;
                    end
                end
            end
            ST_HEADER: begin
                if (xfer) begin
                    if (len_q != '0) begin
                        data_d   = pl_data;
                        parity_d = parity_q ^ pl_data;
                        rem_d    = len_q - 6'd1;
                        state_d  = ST_PAYLOAD;
                    end else begin
                        data_d  = parity_byte;
                        valid_d = 1'b0;
                        state_d = ST_PARITY;
                    end
                end
            end
            ST_PAYLOAD: begin
                // remaining counts bytes still to fetch, so it stops at zero instead of wrapping
                if (xfer) begin
                    if (rem_q != '0) begin
                        data_d   = pl_data;
                        parity_d = parity_q ^ pl_data;
                        rem_d    = rem_q - 6'd1;
                    end else begin
                        data_d  = parity_byte;
                        valid_d = 1'b0;
                        state_d = ST_PARITY;
                    end
                end
            end
            ST_PARITY: begin
                if (xfer) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q    <= ST_IDLE;
            len_q      <= '0;
            rem_q      <= '0;
            err_q      <= 1'b0;
            parity_q   <= 8'h00;
            data_q     <= 8'h00;
            valid_q    <= 1'b0;
            done_q     <= 1'b0;
            addr_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            rem_q      <= rem_d;
            err_q      <= err_d;
            parity_q   <= parity_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            done_q     <= done_d;
            addr_err_q <= addr_err_d;
        end
    end

endmodule

// File: tb/tb_router_pkt_tx.sv
// tb/tb_router_pkt_tx.sv - directed self-checking bench for router_pkt_tx
module tb_router_pkt_tx;

    logic       clock = 1'b0;
    logic       resetn = 1'b0;
    logic       start = 1'b0;
    logic [1:0] dest_addr = 2'd0;
    logic [5:0] payload_len = 6'd0;
    logic       err_inj = 1'b0;
    logic [7:0] pl_data;
    logic       busy = 1'b0;
    logic       pl_rd;
    logic [7:0] data_out;
    logic       pkt_valid;
    logic       ready;
    logic       done;
    logic       addr_err;

    int errors = 0;
    int checks = 0;

    logic [7:0] pl_mem [0:63];
    int         pl_idx = 0;
    logic [7:0] cap_data  [0:79];
    logic       cap_valid [0:79];
    logic [7:0] exp_data  [0:7];
    logic       exp_valid [0:7];
    int         nbytes, nrd, ncyc;

    router_pkt_tx dut (
        .clock(clock), .resetn(resetn), .start(start), .dest_addr(dest_addr),
        .payload_len(payload_len), .err_inj(err_inj), .pl_data(pl_data), .busy(busy),
        .pl_rd(pl_rd), .data_out(data_out), .pkt_valid(pkt_valid), .ready(ready),
        .done(done), .addr_err(addr_err)
    );

    always #5 clock = ~clock;

    assign pl_data = pl_mem[pl_idx];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // advance one clock; the FWFT source pops when pl_rd was high before the edge
    task automatic tick(output logic rd_seen);
        rd_seen = pl_rd;
        @(posedge clock);
        #1;
        if (rd_seen) pl_idx++;
    endtask

    task automatic run_pkt(input logic [1:0] a, input logic [5:0] l, input logic e,
                           input int stall_at, input int stall_n, input logic [7:0] stall_byte,
                           output int n_bytes, output int n_rd, output int n_cyc);
        int   k = 0;
        int   stalled = 0;
        logic rd;
        logic fin = 1'b0;
        n_rd  = 0;
        n_cyc = 0;
        pl_idx = 0;
        start = 1'b1; dest_addr = a; payload_len = l; err_inj = e;
        tick(rd);
        start = 1'b0; dest_addr = 2'd3; payload_len = 6'd63; err_inj = ~e;
        for (int i = 0; i < 200 && !fin; i++) begin
            cap_data[k]  = data_out;
            cap_valid[k] = pkt_valid;
            if (k == stall_at && stalled < stall_n) begin
                busy = 1'b1;
                stalled++;
            end else begin
                busy = 1'b0;
            end
            #1;
            if (busy) begin
                check("stall_data", data_out, stall_byte);
                check("stall_pl_rd", pl_rd, 0);
                check("stall_valid", pkt_valid, 1);
            end
            if (pl_rd) n_rd++;
            tick(rd);
            n_cyc++;
            if (!busy) k++;
            if (done) fin = 1'b1;
        end
        busy = 1'b0;
        if (!fin) check("pkt_timeout", 0, 1);
        n_bytes = k;
        tick(rd);
        check("done_one_cycle", done, 0);
    endtask

    task automatic check_bytes(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            check({tag, "_data"}, cap_data[i], exp_data[i]);
            check({tag, "_valid"}, cap_valid[i], exp_valid[i]);
        end
    endtask

    initial begin
        logic rd;
        for (int i = 0; i < 64; i++) pl_mem[i] = 8'(i + 1);

        #2;
        check("rst_data", data_out, 8'h00);
        check("rst_valid", pkt_valid, 0);
        check("rst_ready", ready, 1);
        check("rst_pl_rd", pl_rd, 0);
        check("rst_done", done, 0);
        check("rst_addr_err", addr_err, 0);
        @(negedge clock);
        resetn = 1'b1;
        @(posedge clock); #1;

        // addr 2, len 5, payload 01..05
        exp_data[0] = 8'h16; exp_data[1] = 8'h01; exp_data[2] = 8'h02; exp_data[3] = 8'h03;
        exp_data[4] = 8'h04; exp_data[5] = 8'h05; exp_data[6] = 8'h17;
        for (int i = 0; i < 7; i++) exp_valid[i] = (i < 6);
        run_pkt(2'd2, 6'd5, 1'b0, -1, 0, 8'h00, nbytes, nrd, ncyc);
        check("p1_bytes", nbytes, 7);
        check("p1_pl_rd", nrd, 5);
        check("p1_cycles", ncyc, 7);
        check_bytes("p1", 7);

        // same packet, corrupted parity
        exp_data[6] = 8'h16;
        run_pkt(2'd2, 6'd5, 1'b1, -1, 0, 8'h00, nbytes, nrd, ncyc);
        check("p2_bytes", nbytes, 7);
        check("p2_pl_rd", nrd, 5);
        check_bytes("p2", 7);

        // empty payload
        exp_data[0] = 8'h01; exp_valid[0] = 1'b1;
        exp_data[1] = 8'h01; exp_valid[1] = 1'b0;
        run_pkt(2'd1, 6'd0, 1'b0, -1, 0, 8'h00, nbytes, nrd, ncyc);
        check("p3_bytes", nbytes, 2);
        check("p3_pl_rd", nrd, 0);
        check("p3_cycles", ncyc, 2);
        check_bytes("p3", 2);

        // stall 3 cycles while byte 03 is presented
        exp_data[0] = 8'h16; exp_data[1] = 8'h01; exp_data[2] = 8'h02; exp_data[3] = 8'h03;
        exp_data[4] = 8'h04; exp_data[5] = 8'h05; exp_data[6] = 8'h17;
        for (int i = 0; i < 7; i++) exp_valid[i] = (i < 6);
        run_pkt(2'd2, 6'd5, 1'b0, 3, 3, 8'h03, nbytes, nrd, ncyc);
        check("p4_bytes", nbytes, 7);
        check("p4_pl_rd", nrd, 5);
        check("p4_cycles", ncyc, 10);
        check_bytes("p4", 7);

        // invalid destination
        start = 1'b1; dest_addr = 2'd3; payload_len = 6'd4; err_inj = 1'b0;
        tick(rd);
        start = 1'b0;
        check("bad_addr_err", addr_err, 1);
        check("bad_ready", ready, 1);
        check("bad_valid", pkt_valid, 0);
        tick(rd);
        check("bad_addr_err_pulse", addr_err, 0);
        check("bad_ready_after", ready, 1);

        // reset during payload byte 02
        pl_idx = 0;
        start = 1'b1; dest_addr = 2'd2; payload_len = 6'd5; err_inj = 1'b0;
        tick(rd);
        start = 1'b0;
        for (int i = 0; i < 20 && data_out != 8'h02; i++) tick(rd);
        check("mid_byte_02", data_out, 8'h02);
        resetn = 1'b0;
        #1;
        check("mid_rst_data", data_out, 8'h00);
        check("mid_rst_valid", pkt_valid, 0);
        check("mid_rst_ready", ready, 1);
        check("mid_rst_pl_rd", pl_rd, 0);
        @(negedge clock);
        resetn = 1'b1;
        tick(rd);
        check("mid_no_done", done, 0);

        pl_mem[0] = 8'hAA;
        exp_data[0] = 8'h04; exp_valid[0] = 1'b1;
        exp_data[1] = 8'hAA; exp_valid[1] = 1'b1;
        exp_data[2] = 8'hAE; exp_valid[2] = 1'b0;
        run_pkt(2'd0, 6'd1, 1'b0, -1, 0, 8'h00, nbytes, nrd, ncyc);
        check("p5_bytes", nbytes, 3);
        check("p5_pl_rd", nrd, 1);
        check_bytes("p5", 3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
